mem_bus_ctrl: RTL and testbench

Memory bus controller between the CPU core and the `Memory` model. It accepts instruction-fetch and data load/store requests from the core and arbitrates between them, data first. It drives the `addrs_bus` / `request` / `rw` / `data_bus_write` / `wait_` handshake, latches the big-endian 16-bit read word, and returns a one-cycle acknowledge per request. It also detects out-of-range addresses and bus timeouts.

---
 rtl/cpu_sam_pkg.sv | 46 ++++
 rtl/bus_timeout_counter.sv | 50 +++++
 rtl/mem_bus_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_sam_pkg.sv
// -----------------------------------------------------------------------------
// cpu_sam_pkg
// Shared definitions for the CPU core / memory bus slice: bus widths, the
// memory-controller state encoding, the request-source encoding, opcode
// constants and small address helpers used by the bus controller.
// -----------------------------------------------------------------------------
package cpu_sam_pkg;

    // Bus geometry
    localparam int ADDR_W        = 16;
    localparam int DATA_W        = 16;
    localparam int MEM_ADDR_BITS = 14;
    localparam int HI_ADDR_BITS  = ADDR_W - MEM_ADDR_BITS;

    // Core opcodes
    localparam logic [1:0] LD  = 2'b00;
    localparam logic [1:0] ST  = 2'b01;
    localparam logic [1:0] ADD = 2'b10;
    localparam logic [1:0] BRN = 2'b11;

    // Memory bus controller states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } bus_state_e;

    // Which client owns the access in flight
    typedef enum logic {
        SRC_FETCH = 1'b0,
        SRC_DATA  = 1'b1
    } bus_src_e;

    // True when the upper address bits select the implemented memory.
    function automatic logic addr_in_range(input logic [HI_ADDR_BITS-1:0] hi_bits);
        return (hi_bits == {HI_ADDR_BITS{1'b0}});
    endfunction

    // Bus address: the upper bits are never driven high.
    function automatic logic [ADDR_W-1:0] bus_addr(input logic [MEM_ADDR_BITS-1:0] lo_bits);
        return {{HI_ADDR_BITS{1'b0}}, lo_bits};
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// -----------------------------------------------------------------------------
// bus_timeout_counter
// Counts cycles while a bus access is outstanding and flags when the
// configured budget is used up.
//   clk_i   : system clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   clr_i   : synchronous clear (has priority over en_i)
//   en_i    : count this cycle
//   tc_o    : terminal count; high in the TIMEOUT_CYCLES-th enabled cycle
// -----------------------------------------------------------------------------
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    // Value held by the counter during the last cycle of the budget.
    localparam logic [7:0] TC_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: clear wins, saturate at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i && (cnt_q != TC_LAST)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && (cnt_q == TC_LAST);

endmodule

// File: rtl/mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bus_ctrl
// Memory bus controller between the CPU core and the Memory model. Arbitrates
// instruction fetches against data loads/stores (data wins), runs the
// request / rw / data_bus_write / wait_ handshake, and returns a one-cycle
// acknowledge per request with an error flag for out-of-range addresses and
// bus timeouts. All outputs are registered.
//
// Ports
//   clk_i, reset_ni           : clock, asynchronous active-low reset
//   if_req_i, if_addr_i       : fetch request and byte address
//   if_ack_o, if_rdata_o      : fetch done pulse, fetched word (held)
//   d_req_i, d_we_i           : data request, 1 = store
//   d_addr_i, d_wdata_i       : data byte address, store word
//   d_ack_o, d_rdata_o        : data done pulse, load word
//   err_o                     : with an ack, address error or timeout
//   busy_o                    : controller not idle
//   mem_addr_o, mem_req_o     : to addrs_bus, request
//   mem_rw_o, mem_wdata_o     : to rw (1 = read), data_bus_write
//   mem_wait_ni, mem_rdata_i  : from wait_ (active low), data_bus_read
// -----------------------------------------------------------------------------
module mem_bus_ctrl
    import cpu_sam_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              err_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_req_o,
    output logic              mem_rw_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_wait_ni,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    // FSM
    bus_state_e state_q, state_d;

    // Latched request
    bus_src_e                 src_q, src_d;
    logic                     we_q, we_d;
    logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]        wdata_q, wdata_d;
    logic [DATA_W-1:0]        rd_q, rd_d;

    // Registered outputs
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_rw_q, mem_rw_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    // Arbitration winner (only meaningful in IDLE)
    logic              any_req_s;
    bus_src_e          win_src_s;
    logic              win_we_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_wdata_s;

    // Request being served this cycle: the winner while idle, else the latch
    bus_src_e                 cur_src_s;
    logic                     cur_we_s;
    logic [MEM_ADDR_BITS-1:0] cur_addr_s;
    logic [DATA_W-1:0]        cur_wdata_s;

    // Timeout
    logic tmr_clr_s;
    logic tmr_en_s;
    logic tmr_tc_s;
    logic timeout_s;
    logic [DATA_W-1:0] result_s;

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmr (
        .clk_i  (clk_i),
        .rst_ni (reset_ni),
        .clr_i  (tmr_clr_s),
        .en_i   (tmr_en_s),
        .tc_o   (tmr_tc_s)
    );

    // Fixed-priority arbitration: a pending data access beats a fetch.
    always_comb begin
        any_req_s = d_req_i | if_req_i;
        if (d_req_i) begin
            win_src_s   = SRC_DATA;
            win_we_s    = d_we_i;
            win_addr_s  = d_addr_i;
            win_wdata_s = d_wdata_i;
        end else begin
            win_src_s   = SRC_FETCH;
            win_we_s    = 1'b0;
            win_addr_s  = if_addr_i;
            win_wdata_s = {DATA_W{1'b0}};
        end
    end

    // Select the live request fields for the output logic.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_src_s   = win_src_s;
            cur_we_s    = win_we_s;
            cur_addr_s  = win_addr_s[MEM_ADDR_BITS-1:0];
            cur_wdata_s = win_wdata_s;
        end else begin
            cur_src_s   = src_q;
            cur_we_s    = we_q;
            cur_addr_s  = addr_q;
            cur_wdata_s = wdata_q;
        end
    end

    // Timer control and timeout detection. A completion seen in the same
    // cycle as the terminal count takes precedence over the timeout.
    always_comb begin
        tmr_clr_s = (state_q == ST_SETUP);
        tmr_en_s  = (state_q == ST_ACCESS) || (state_q == ST_RELEASE);
        if (state_q == ST_ACCESS) begin
            timeout_s = tmr_tc_s && mem_wait_ni;
        end else if (state_q == ST_RELEASE) begin
            timeout_s = tmr_tc_s && !mem_wait_ni;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!any_req_s) begin
                    state_d = ST_IDLE;
                end else if (addr_in_range(win_addr_s[ADDR_W-1:MEM_ADDR_BITS])) begin
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (!mem_wait_ni) begin
                    state_d = ST_RELEASE;
                end else if (timeout_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_RELEASE: begin
                if (mem_wait_ni || timeout_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request latch: capture the winner when leaving IDLE.
    always_comb begin
        if ((state_q == ST_IDLE) && any_req_s) begin
            src_d   = win_src_s;
            we_d    = win_we_s;
            addr_d  = win_addr_s[MEM_ADDR_BITS-1:0];
            wdata_d = win_wdata_s;
        end else begin
            src_d   = src_q;
            we_d    = we_q;
            addr_d  = addr_q;
            wdata_d = wdata_q;
        end
    end

    // Output logic: next values of every registered output, derived from
    // the state being entered. rw/wdata are set up a cycle before request
    // rises because Memory writes on any change while request is high.
    always_comb begin
        mem_req_d = (state_d == ST_ACCESS);
        busy_d    = (state_d != ST_IDLE);

        if ((state_d == ST_SETUP) || (state_d == ST_ACCESS)) begin
            mem_rw_d = ~cur_we_s;
        end else begin
            mem_rw_d = 1'b1;
        end

        if (((state_d == ST_SETUP) || (state_d == ST_ACCESS) ||
             (state_d == ST_RELEASE)) && cur_we_s) begin
            mem_wdata_d = cur_wdata_s;
        end else begin
            mem_wdata_d = {DATA_W{1'b0}};
        end

        if (state_d == ST_SETUP) begin
            mem_addr_d = bus_addr(cur_addr_s);
        end else begin
            mem_addr_d = mem_addr_q;
        end

        // DONE is entered for exactly one cycle, so the acks are pulses.
        if (state_d == ST_DONE) begin
            if_ack_d = (cur_src_s == SRC_FETCH);
            d_ack_d  = (cur_src_s == SRC_DATA);
            err_d    = (state_q == ST_IDLE) || timeout_s;
        end else begin
            if_ack_d = 1'b0;
            d_ack_d  = 1'b0;
            err_d    = 1'b0;
        end

        // Read word is captured in the ACCESS cycle where wait_ is low.
        if ((state_q == ST_ACCESS) && !mem_wait_ni && !cur_we_s) begin
            rd_d = mem_rdata_i;
        end else begin
            rd_d = rd_q;
        end

        // A timed-out read returns zero; address errors leave rdata alone.
        if (timeout_s) begin
            result_s = {DATA_W{1'b0}};
        end else begin
            result_s = rd_q;
        end

        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if ((state_d == ST_DONE) && (state_q != ST_IDLE) && !cur_we_s) begin
            if (cur_src_s == SRC_FETCH) begin
                if_rdata_d = result_s;
            end else begin
                d_rdata_d = result_s;
            end
        end else begin
            if_rdata_d = if_rdata_q;
            d_rdata_d  = d_rdata_q;
        end
    end

    // State and request latch registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            src_q   <= SRC_FETCH;
            we_q    <= 1'b0;
            addr_q  <= {MEM_ADDR_BITS{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            rd_q    <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_req_q   <= 1'b0;
            mem_rw_q    <= 1'b1;
            mem_wdata_q <= {DATA_W{1'b0}};
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= {DATA_W{1'b0}};
            d_rdata_q   <= {DATA_W{1'b0}};
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_req_q   <= mem_req_d;
            mem_rw_q    <= mem_rw_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_req_o   = mem_req_q;
    assign mem_rw_o    = mem_rw_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_ack_o    = if_ack_q;
    assign d_ack_o     = d_ack_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_ctrl
// Self-checking bench for mem_bus_ctrl. A byte-array Memory stub answers the
// bus (wait_ follows request, optionally after a programmable delay, or never
// for the timeout case). A separate reference byte array holds the expected
// memory image; expected read data, latencies and error flags are computed
// from it with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_mem_bus_ctrl;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        err;
    logic        busy;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic        mem_rw;
    logic [15:0] mem_wdata;
    logic        mem_wait_n;
    logic [15:0] mem_rdata;

    logic [7:0] mem     [0:16383];
    logic [7:0] ref_mem [0:16383];

    int   total = 0;
    int   bad   = 0;
    bit   init_go = 1'b0;
    bit   init_done = 1'b0;
    bit   stub_hang = 1'b0;
    int   stub_delay = 0;
    int   req_cnt = 0;
    logic [15:0] exp_if = 16'h0000;
    logic [15:0] exp_d  = 16'h0000;

    always #5 clk = ~clk;

    mem_bus_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i       (clk),
        .reset_ni    (reset_n),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_ack_o    (if_ack),
        .if_rdata_o  (if_rdata),
        .d_req_i     (d_req),
        .d_we_i      (d_we),
        .d_addr_i    (d_addr),
        .d_wdata_i   (d_wdata),
        .d_ack_o     (d_ack),
        .d_rdata_o   (d_rdata),
        .err_o       (err),
        .busy_o      (busy),
        .mem_addr_o  (mem_addr),
        .mem_req_o   (mem_req),
        .mem_rw_o    (mem_rw),
        .mem_wdata_o (mem_wdata),
        .mem_wait_ni (mem_wait_n),
        .mem_rdata_i (mem_rdata)
    );

    // Memory stub: big-endian combinational read.
    assign mem_rdata = {mem[mem_addr[13:0]], mem[mem_addr[13:0] + 14'd1]};

    // Memory stub: wait_ low while request is high, after stub_delay cycles.
    always_comb begin
        if (stub_hang) begin
            mem_wait_n = 1'b1;
        end else if ((mem_req === 1'b1) && (req_cnt >= stub_delay)) begin
            mem_wait_n = 1'b0;
        end else begin
            mem_wait_n = 1'b1;
        end
    end

    // Memory stub: image load, writes, and request-high cycle counter.
    always @(posedge clk) begin
        if (init_go && !init_done) begin
            for (int i = 0; i < 16384; i++) mem[i] <= ref_mem[i];
            init_done <= 1'b1;
        end else if ((mem_req === 1'b1) && (mem_rw === 1'b0)) begin
            mem[mem_addr[13:0]]         <= mem_wdata[15:8];
            mem[mem_addr[13:0] + 14'd1] <= mem_wdata[7:0];
        end
        req_cnt <= (mem_req === 1'b1) ? req_cnt + 1 : 0;
    end

    // One request through the controller. Cycle 0 is the cycle the request
    // is driven in; cycle k is sampled on the k-th following falling edge.
    task automatic run_xact(input logic is_data, input logic we,
                            input logic [15:0] addr, input logic [15:0] wdata,
                            output logic [15:0] rdata, output logic err_seen,
                            output int lat, output int req_cycles,
                            output int req_first, output logic bus_bad);
        logic st;
        st = is_data & we;
        rdata = 16'h0000; err_seen = 1'b0; lat = -1;
        req_cycles = 0; req_first = -1; bus_bad = 1'b0;
        if (is_data) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); @(negedge clk);
            if (busy !== 1'b1) bus_bad = 1'b1;
            if (mem_req === 1'b1) begin
                req_cycles++;
                if (req_first < 0) req_first = k;
                if (mem_rw !== ~st || mem_addr !== {2'b00, addr[13:0]} ||
                    mem_wdata !== (st ? wdata : 16'h0000)) bus_bad = 1'b1;
            end
            if ((is_data ? if_ack : d_ack) === 1'b1) bus_bad = 1'b1;
            if ((is_data ? d_ack : if_ack) === 1'b1) begin
                lat = k;
                rdata = is_data ? d_rdata : if_rdata;
                err_seen = err;
                break;
            end
        end
        d_req = 1'b0; if_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        if (busy !== 1'b0 || if_ack !== 1'b0 || d_ack !== 1'b0) bus_bad = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clk);
        total++;
        if (mem_req !== 1'b0 || mem_rw !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_ctl: req/rw/busy got %b%b%b want 010", mem_req, mem_rw, busy);
        end
        total++;
        if (mem_addr !== 16'h0000 || mem_wdata !== 16'h0000) begin
            bad++; $display("FAIL reset_bus: addr %h wdata %h want 0000 0000", mem_addr, mem_wdata);
        end
        total++;
        if (if_ack !== 1'b0 || d_ack !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL reset_ack: if_ack %b d_ack %b err %b want 000", if_ack, d_ack, err);
        end
        total++;
        if (if_rdata !== 16'h0000 || d_rdata !== 16'h0000) begin
            bad++; $display("FAIL reset_rdata: if %h d %h want 0000 0000", if_rdata, d_rdata);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            bad++; $display("FAIL reset_idle: busy %b req %b want 0 0", busy, mem_req);
        end
    endtask

    task automatic test_fetch();
        logic [15:0] rd; logic e; int lat, rc, rf; logic bb;
        run_xact(1'b0, 1'b0, 16'h0000, 16'h0000, rd, e, lat, rc, rf, bb);
        exp_if = 16'h0080;
        total++;
        if (rf != 2 || rc != 1) begin
            bad++; $display("FAIL fetch_req_window: first %0d count %0d want 2 1", rf, rc);
        end
        total++;
        if (lat != 4 || rd !== 16'h0080 || e !== 1'b0) begin
            bad++; $display("FAIL fetch_ack: lat %0d data %h err %b want 4 0080 0", lat, rd, e);
        end
        total++;
        if (bb !== 1'b0) begin
            bad++; $display("FAIL fetch_bus: bus/busy/ack protocol error %b want 0", bb);
        end
    endtask

    task automatic test_store_load();
        logic [15:0] rd; logic e; int lat, rc, rf; logic bb;
        run_xact(1'b1, 1'b1, 16'h0084, 16'habce, rd, e, lat, rc, rf, bb);
        ref_mem[132] = 8'hab; ref_mem[133] = 8'hce;
        total++;
        if (lat != 4 || rc != 1 || e !== 1'b0 || bb !== 1'b0) begin
            bad++; $display("FAIL store_cycle: lat %0d req %0d err %b bus %b want 4 1 0 0", lat, rc, e, bb);
        end
        total++;
        if (mem[132] !== 8'hab || mem[133] !== 8'hce) begin
            bad++; $display("FAIL store_mem: %h %h want ab ce", mem[132], mem[133]);
        end
        total++;
        if (d_rdata !== exp_d) begin
            bad++; $display("FAIL store_rdata: d_rdata %h want %h", d_rdata, exp_d);
        end
        run_xact(1'b1, 1'b0, 16'h0084, 16'h0000, rd, e, lat, rc, rf, bb);
        exp_d = 16'habce;
        total++;
        if (lat != 4 || rd !== 16'habce || e !== 1'b0 || bb !== 1'b0) begin
            bad++; $display("FAIL load_back: lat %0d data %h err %b bus %b want 4 abce 0 0", lat, rd, e, bb);
        end
    endtask

    task automatic test_arbitration();
        int d_lat, i_lat; logic [15:0] d_val, i_val;
        d_lat = -1; i_lat = -1; d_val = 16'h0000; i_val = 16'h0000;
        if_req = 1'b1; if_addr = 16'h0002;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0080; d_wdata = 16'h0000;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); @(negedge clk);
            if (d_ack === 1'b1 && d_lat < 0) begin d_lat = k; d_val = d_rdata; d_req = 1'b0; end
            if (if_ack === 1'b1 && i_lat < 0) begin i_lat = k; i_val = if_rdata; if_req = 1'b0; end
            if (d_lat >= 0 && i_lat >= 0) break;
        end
        d_req = 1'b0; if_req = 1'b0;
        @(negedge clk);
        exp_d = 16'habcd; exp_if = 16'h8082;
        total++;
        if (d_lat != 4 || d_val !== 16'habcd) begin
            bad++; $display("FAIL arb_data_first: lat %0d data %h want 4 abcd", d_lat, d_val);
        end
        total++;
        if (i_lat != 9 || i_val !== 16'h8082) begin
            bad++; $display("FAIL arb_fetch_second: lat %0d data %h want 9 8082", i_lat, i_val);
        end
    endtask

    task automatic test_addr_err();
        logic [15:0] rd; logic e; int lat, rc, rf; logic bb;
        run_xact(1'b1, 1'b0, 16'h4000, 16'h0000, rd, e, lat, rc, rf, bb);
        total++;
        if (lat != 1 || e !== 1'b1 || rc != 0 || bb !== 1'b0) begin
            bad++; $display("FAIL addr_err_load: lat %0d err %b req %0d bus %b want 1 1 0 0", lat, e, rc, bb);
        end
        total++;
        if (rd !== exp_d) begin
            bad++; $display("FAIL addr_err_rdata: d_rdata %h want %h", rd, exp_d);
        end
        run_xact(1'b0, 1'b0, 16'hc002, 16'h0000, rd, e, lat, rc, rf, bb);
        total++;
        if (lat != 1 || e !== 1'b1 || rc != 0 || rd !== exp_if || bb !== 1'b0) begin
            bad++; $display("FAIL addr_err_fetch: lat %0d err %b req %0d data %h want 1 1 0 %h", lat, e, rc, rd, exp_if);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] rd; logic e; int lat, rc, rf; logic bb;
        stub_hang = 1'b1;
        run_xact(1'b1, 1'b0, 16'h0100, 16'h0000, rd, e, lat, rc, rf, bb);
        stub_hang = 1'b0;
        exp_d = 16'h0000;
        total++;
        if (rc != TMO || lat != TMO + 2) begin
            bad++; $display("FAIL timeout_len: req cycles %0d lat %0d want %0d %0d", rc, lat, TMO, TMO + 2);
        end
        total++;
        if (e !== 1'b1 || rd !== 16'h0000 || bb !== 1'b0) begin
            bad++; $display("FAIL timeout_result: err %b data %h bus %b want 1 0000 0", e, rd, bb);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [15:0] rd; logic e; int lat, rc, rf; logic bb; logic ack_seen;
        if_req = 1'b1; if_addr = 16'h0002;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        total++;
        if (mem_req !== 1'b1) begin
            bad++; $display("FAIL midrst_in_access: mem_req %b want 1", mem_req);
        end
        reset_n = 1'b0; if_req = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b0 || mem_rw !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL midrst_async: req %b rw %b busy %b want 0 1 0", mem_req, mem_rw, busy);
        end
        @(negedge clk); reset_n = 1'b1;
        exp_if = 16'h0000; exp_d = 16'h0000;
        ack_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (if_ack !== 1'b0 || d_ack !== 1'b0) ack_seen = 1'b1;
        end
        total++;
        if (ack_seen !== 1'b0 || if_rdata !== 16'h0000) begin
            bad++; $display("FAIL midrst_no_ack: ack %b if_rdata %h want 0 0000", ack_seen, if_rdata);
        end
        run_xact(1'b0, 1'b0, 16'h0002, 16'h0000, rd, e, lat, rc, rf, bb);
        exp_if = 16'h8082;
        total++;
        if (lat != 4 || rd !== 16'h8082 || e !== 1'b0 || bb !== 1'b0) begin
            bad++; $display("FAIL midrst_reissue: lat %0d data %h err %b bus %b want 4 8082 0 0", lat, rd, e, bb);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic is_data, we, oob;
            logic [15:0] a, wd, rd, ev;
            logic [13:0] a0, a1;
            logic e, bb;
            int lat, rc, rf, exp_lat, exp_rc;
            is_data = ($urandom_range(0, 1) == 1);
            we      = is_data && ($urandom_range(0, 1) == 1);
            a       = 16'($urandom);
            if ($urandom_range(0, 7) != 0) a[15:14] = 2'b00;
            wd      = 16'($urandom);
            stub_delay = int'($urandom_range(0, 5));
            oob     = (a[15:14] != 2'b00);
            a0      = a[13:0];
            a1      = a0 + 14'd1;
            ev      = {ref_mem[a0], ref_mem[a1]};
            exp_lat = oob ? 1 : 4 + stub_delay;
            exp_rc  = oob ? 0 : stub_delay + 1;
            run_xact(is_data, we, a, wd, rd, e, lat, rc, rf, bb);
            if (!oob && we) begin
                ref_mem[a0] = wd[15:8];
                ref_mem[a1] = wd[7:0];
            end
            if (!oob && !we) begin
                if (is_data) exp_d = ev; else exp_if = ev;
            end
            total++;
            if (lat != exp_lat || rc != exp_rc || e !== oob || bb !== 1'b0) begin
                bad++;
                $display("FAIL rand_xact[%0d] d=%b we=%b a=%h: lat %0d req %0d err %b bus %b want %0d %0d %b 0",
                         n, is_data, we, a, lat, rc, e, bb, exp_lat, exp_rc, oob);
            end
            total++;
            if (if_rdata !== exp_if || d_rdata !== exp_d) begin
                bad++;
                $display("FAIL rand_rdata[%0d] a=%h: if %h d %h want %h %h", n, a, if_rdata, d_rdata, exp_if, exp_d);
            end
        end
        stub_delay = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        if_req = 1'b0; if_addr = 16'h0000;
        d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
        for (int i = 0; i < 16384; i++) ref_mem[i] = 8'($urandom);
        ref_mem[0]   = 8'h00; ref_mem[1]   = 8'h80;
        ref_mem[2]   = 8'h80; ref_mem[3]   = 8'h82;
        ref_mem[128] = 8'hab; ref_mem[129] = 8'hcd;
        ref_mem[132] = 8'h00; ref_mem[133] = 8'h00;
        ref_mem[256] = 8'h5a; ref_mem[257] = 8'ha5;
        init_go = 1'b1;
        for (int i = 0; i < 10 && !init_done; i++) @(posedge clk);
        total++;
        if (init_done !== 1'b1) begin
            bad++; $display("FAIL stub_init: memory image not loaded");
        end
        test_reset();
        test_fetch();
        test_store_load();
        test_arbitration();
        test_addr_err();
        test_timeout();
        test_reset_mid_access();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
